// File: rtl/fifo_tx_serializer.sv
// Pops words from a synchronous FIFO and shifts each one out LSB-first on a single wire with start/stop framing.
// Define FIFO_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module fifo_tx_serializer #(
  parameter int DATA_W     = 4,
  parameter int BIT_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              pop,
  output logic              tx,
  output logic              busy,
  output logic              frame_done
);

  localparam int               IDX_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [7:0]       LAST_CYC = 8'(BIT_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_POP    = 3'd1,
    S_LOAD   = 3'd2,
    S_START  = 3'd3,
    S_DATA   = 3'd4,
`ifdef FIFO_TX_PARITY_EN
    S_PARITY = 3'd5,
`endif
    S_STOP   = 3'd6
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        cyc_q, cyc_d;
  logic [IDX_W-1:0]  bit_q, bit_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              pop_d, tx_d, busy_d, frame_done_d;
  logic              bit_end, start_ok;
`ifdef FIFO_TX_PARITY_EN
  logic              parity_q, parity_d;
`endif

  assign bit_end  = (cyc_q == LAST_CYC);
  assign start_ok = enable && !fifo_empty;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    state_d      = state_q;
    cyc_d        = cyc_q;
    bit_d        = bit_q;
    shreg_d      = shreg_q;
`ifdef FIFO_TX_PARITY_EN
    parity_d     = parity_q;
`endif

    case (state_q)
      S_IDLE: if (start_ok) state_d = S_POP;
      S_POP:  state_d = S_LOAD;
      S_LOAD: begin
        shreg_d = fifo_data;
        cyc_d   = '0;
        bit_d   = '0;
`ifdef FIFO_TX_PARITY_EN
        parity_d = 1'b0;
`endif
        state_d = S_START;
      end
      S_START: begin
        cyc_d = bit_end ? 8'd0 : cyc_q + 8'd1;
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        cyc_d = bit_end ? 8'd0 : cyc_q + 8'd1;
        if (bit_end) begin
          // Parity folds in each bit as it leaves, so it is complete when DATA ends.
`ifdef FIFO_TX_PARITY_EN
          parity_d = parity_q ^ shreg_q[0];
`endif
          shreg_d = shreg_q >> 1;
          if (bit_q == LAST_BIT) begin
            bit_d = '0;
`ifdef FIFO_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
`ifdef FIFO_TX_PARITY_EN
      S_PARITY: begin
        cyc_d = bit_end ? 8'd0 : cyc_q + 8'd1;
        if (bit_end) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        cyc_d = bit_end ? 8'd0 : cyc_q + 8'd1;
        if (bit_end) state_d = start_ok ? S_POP : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next-state values so they can be registered with no added latency.
    pop_d        = (state_d == S_POP);
    busy_d       = (state_d != S_IDLE);
    frame_done_d = (state_d == S_STOP) && (cyc_d == LAST_CYC);
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shreg_d[0];
`ifdef FIFO_TX_PARITY_EN
      S_PARITY: tx_d = parity_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    if (reset) begin
      state_q    <= S_IDLE;
      cyc_q      <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
      pop        <= 1'b0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
`ifdef FIFO_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      pop        <= pop_d;
      tx         <= tx_d;
      busy       <= busy_d;
      frame_done <= frame_done_d;
`ifdef FIFO_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_fifo_tx_serializer.sv
// Scoreboard bench for fifo_tx_serializer: a FIFO model feeds the DUT, expected frames are queued at push time
// and a negedge monitor reassembles each serial frame and compares it against the queue head.
module tb_fifo_tx_serializer;

  localparam int DATA_W = 4;
  localparam int BC     = 4;
`ifdef FIFO_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NB = DATA_W + 2 + PAR;
  localparam int FL = NB * BC;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic fifo_empty;
  logic [3:0] fifo_data = 4'h0;
  logic pop, tx, busy, frame_done;

  logic enable1 = 1'b0;
  logic fifo1_empty;
  logic [3:0] fifo1_data = 4'h0;
  logic pop1, tx1, busy1, frame_done1;

  always #5 clk = ~clk;

  fifo_tx_serializer #(.DATA_W(DATA_W), .BIT_CYCLES(BC)) u_dut (
    .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .pop(pop), .tx(tx), .busy(busy), .frame_done(frame_done));

  fifo_tx_serializer #(.DATA_W(DATA_W), .BIT_CYCLES(1)) u_dut1 (
    .clk(clk), .reset(reset), .enable(enable1), .fifo_empty(fifo1_empty), .fifo_data(fifo1_data),
    .pop(pop1), .tx(tx1), .busy(busy1), .frame_done(frame_done1));

  // FIFO models: written by stimulus, read on pop.
  logic [3:0] mem [0:31];
  int wr_ptr = 0, rd_ptr = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);
  always @(posedge clk) if (pop && !fifo_empty) begin
    fifo_data <= mem[rd_ptr % 32];
    rd_ptr    <= rd_ptr + 1;
  end

  logic [3:0] mem1;
  int wr1 = 0, rd1 = 0;
  assign fifo1_empty = (wr1 == rd1);
  always @(posedge clk) if (pop1 && !fifo1_empty) begin
    fifo1_data <= mem1;
    rd1        <= rd1 + 1;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0] word;
    int         gap;
  } exp_t;
  exp_t exp_q[$];

  int n_vec = 0, n_err = 0;
  int pop_cnt = 0, last_pop_cyc = 0, last_end = 0, frames_seen = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Per-cycle tx image of one frame: start 0, data LSB first, optional even parity, stop 1.
  function automatic logic [31:0] frame_cycles(input logic [3:0] w, input int bc);
    logic [7:0]  b;
    logic [31:0] v;
    b    = 8'hFF;
    b[0] = 1'b0;
    for (int i = 0; i < 4; i++) b[i+1] = w[i];
    if (PAR == 1) b[5] = ^w;
    v = '0;
    for (int c = 0; c < NB * bc; c++) v[c] = b[c / bc];
    return v;
  endfunction

  // Monitor: reassembles frames from the line and compares them with the scoreboard.
  initial begin
    int          k;
    bit          in_frame;
    bit          all_busy;
    int          cur_gap;
    logic [31:0] got, gfd;
    exp_t        e;
    in_frame = 0;
    k = 0;
    cur_gap = 0;
    all_busy = 1;
    got = '0;
    gfd = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        in_frame = 0;
        continue;
      end
      if (pop) begin
        pop_cnt++;
        last_pop_cyc = cyc;
        check("pop_while_empty", 32'(fifo_empty), 32'd0);
      end
      if (!in_frame && busy && tx == 1'b0) begin
        in_frame = 1;
        k = 0;
        got = '0;
        gfd = '0;
        all_busy = 1;
        cur_gap = cyc - last_end - 1;
        check("pop_to_start", 32'(cyc - last_pop_cyc), 32'd2);
      end
      if (in_frame) begin
        got[k] = tx;
        gfd[k] = frame_done;
        if (!busy) all_busy = 0;
        k++;
        if (k == FL) begin
          in_frame = 0;
          last_end = cyc;
          frames_seen++;
          if (exp_q.size() == 0) begin
            check("unexpected_frame", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("frame_tx", got, frame_cycles(e.word, BC));
            check("frame_done", gfd, 32'd1 << (FL - 1));
            check("busy_in_frame", 32'(all_busy), 32'd1);
            if (e.gap >= 0) check("frame_gap", 32'(cur_gap), 32'(e.gap));
          end
        end
      end
    end
  end

  task automatic push(input logic [3:0] w, input int gap, input bit expect_frame);
    exp_t e;
    mem[wr_ptr % 32] = w;
    wr_ptr++;
    if (expect_frame) begin
      e.word = w;
      e.gap  = gap;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_frames(input int target, input int budget, input string name);
    int n = 0;
    while (frames_seen < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_frames"}, 32'(frames_seen), 32'(target));
  endtask

  task automatic wait_start(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(busy && tx == 1'b0) && n < 100);
    check({name, "_start_seen"}, 32'(busy && tx == 1'b0), 32'd1);
  endtask

  initial begin
    int p0, f0, bad, n;
    logic [31:0] got1, fd1v;

    // Reset values.
    repeat (3) @(negedge clk);
    check("reset_outputs", {28'd0, tx, pop, busy, frame_done}, 32'b1000);
    reset = 1'b0;

    // Idle with an empty FIFO.
    enable = 1'b1;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if ({tx, pop, busy} !== 3'b100) bad++;
    end
    check("idle_empty_violations", 32'(bad), 32'd0);

    // Single word 4'hA.
    p0 = pop_cnt;
    push(4'hA, -1, 1);
    wait_frames(1, 200, "single_A");
    repeat (4) @(negedge clk);
    check("single_A_pops", 32'(pop_cnt - p0), 32'd1);
    check("single_A_idle", {30'd0, busy, tx}, 32'b01);

    // Three queued words back to back.
    p0 = pop_cnt;
    push(4'h1, -1, 1);
    push(4'h7, 2, 1);
    push(4'hF, 2, 1);
    wait_frames(4, 400, "burst");
    repeat (4) @(negedge clk);
    check("burst_pops", 32'(pop_cnt - p0), 32'd3);
    check("burst_fifo_empty", 32'(fifo_empty), 32'd1);

    // Reset during DATA of a 4'h5 frame.
    f0 = frames_seen;
    push(4'h5, -1, 0);
    wait_start("reset_mid");
    repeat (BC + 2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("reset_mid_tx_busy", {30'd0, tx, busy}, 32'b10);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    p0 = pop_cnt;
    repeat (20) @(negedge clk);
    check("reset_mid_no_pop", 32'(pop_cnt - p0), 32'd0);
    check("reset_mid_no_frame", 32'(frames_seen), 32'(f0));
    check("reset_mid_idle", {30'd0, busy, tx}, 32'b01);

    // Enable dropped during START with two words queued.
    p0 = pop_cnt;
    push(4'h3, -1, 1);
    push(4'h9, -1, 0);
    wait_start("enable_drop");
    enable = 1'b0;
    wait_frames(f0 + 1, 200, "enable_drop");
    repeat (30) @(negedge clk);
    check("enable_drop_pops", 32'(pop_cnt - p0), 32'd1);
    check("enable_drop_idle", {30'd0, busy, tx}, 32'b01);
    check("enable_drop_fifo_left", 32'(fifo_empty), 32'd0);

    // BIT_CYCLES=1 instance with 4'hC.
    mem1 = 4'hC;
    wr1++;
    enable1 = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!pop1 && n < 20);
    check("bc1_pop_seen", 32'(pop1), 32'd1);
    enable1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    got1 = '0;
    fd1v = '0;
    for (int c = 0; c < NB; c++) begin
      got1[c] = tx1;
      fd1v[c] = frame_done1;
      @(negedge clk);
    end
    check("bc1_frame_tx", got1, frame_cycles(4'hC, 1));
    check("bc1_frame_done", fd1v, 32'd1 << (NB - 1));
    check("bc1_idle_after", {30'd0, busy1, tx1}, 32'b01);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fifo_tx_serializer.md
# fifo_tx_serializer

Read-side consumer for the 4-bit synchronous circular FIFO. It pops one word at a time through the FIFO's `pop`/`data_out`/`fifo_empty` interface and shifts each word out on a single-wire serial line with start/stop framing. It sits between the FIFO and an off-block serial sink, so buffered words leave the design one bit per bit-period.

## Interface
- `DATA_W`, 4: word width; must match the FIFO data width.
- `BIT_CYCLES`, 4: clock cycles per serial bit; legal range 1..255.

- `clk`  in  1  single clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `enable`  in  1  permits starting a new pop/frame; does not abort a frame already in progress.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_data`  in  DATA_W  FIFO `data_out`; valid the cycle after `pop` is sampled.
- `pop`  out  1  pop strobe to the FIFO; high for exactly one cycle per word.
- `tx`  out  1  serial line; idles high.
- `busy`  out  1  high in every state except IDLE.
- `frame_done`  out  1  one-cycle pulse on the last cycle of the stop bit.

## Operation
- States: IDLE, POP, LOAD, START, DATA, PARITY (only with macro), STOP. Moore outputs, all registered.
- IDLE: `tx`=1, `pop`=0. If `enable` && !`fifo_empty` at the edge, go to POP.
- POP: `pop`=1 for one cycle, then go to LOAD unconditionally.
- LOAD: capture `fifo_data` into the shift register, clear the parity accumulator, then go to START.
- START: `tx`=0 for BIT_CYCLES cycles.
- DATA: DATA_W bits, LSB first, each held BIT_CYCLES cycles. Uses a bit index counter (0..DATA_W-1) and an 8-bit cycle counter that wraps to 0 at BIT_CYCLES-1.
- STOP: `tx`=1 for BIT_CYCLES cycles. On the final cycle, `frame_done`=1. Next state is POP if `enable` && !`fifo_empty`, otherwise IDLE.
- Reset values: state=IDLE, `tx`=1, `pop`=0, `busy`=0, `frame_done`=0, counters and shift register 0.
- Reset mid-frame: abort at the next edge. `tx` returns high and the popped word is discarded without retry.
- `enable` falling mid-frame: the frame completes normally. No further pop is issued.
- `fifo_empty` is sampled only in IDLE and in the last STOP cycle. A pop is never issued while `fifo_empty`=1.
- FIFO overwrite-on-full is not visible to this block. It transmits whatever `fifo_data` holds in LOAD.

## Timing
- Trigger edge is sampled in cycle n (IDLE). `pop` is high in n+1, capture happens in n+2, and `tx`=0 starts at n+3.
- Frame length from START to the end of STOP is (DATA_W+2)×BIT_CYCLES cycles, or (DATA_W+3)×BIT_CYCLES with parity.
- Back-to-back frames have a 2-cycle gap (POP, LOAD) of `tx`=1 between the stop bit and the next start bit.
- Minimum spacing between `pop` pulses is one full frame plus 2 cycles.
- BIT_CYCLES=1 is legal: each bit lasts one cycle.

## Configuration
- `FIFO_TX_PARITY_EN` defined: the PARITY state is inserted between DATA and STOP. It drives the even-parity bit (XOR of the DATA_W data bits) for BIT_CYCLES cycles.
- `FIFO_TX_PARITY_EN` undefined: there is no PARITY state and no parity logic. DATA goes directly to STOP.

## Test plan
- Reset, then idle with `fifo_empty`=1 for 50 cycles -> `tx`=1, `pop`=0, `busy`=0 throughout.
- FIFO holds 4'hA, `enable`=1, BIT_CYCLES=4 -> one `pop` pulse, then `tx` sequence 0,0,1,0,1,1 with each bit 4 cycles, and `frame_done` on cycle 24 of the frame. With the macro, the sequence is 0,0,1,0,1,0,1 (parity 0) and the frame is 28 cycles.
- FIFO holds 4'h1, 4'h7, 4'hF -> three frames, each separated by exactly 2 idle-high cycles, and exactly 3 `pop` pulses. The FIFO reports empty afterwards.
- `reset` asserted during the DATA state of a 4'h5 frame -> at the next edge `tx`=1 and `busy`=0. After release, no pop occurs if `fifo_empty`=1.
- `enable` dropped during START with 2 words queued -> the current frame completes, there is no second `pop`, and the block returns to IDLE.
- BIT_CYCLES=1 with 4'hC and the macro defined -> `tx`=0,0,0,1,1,0,1 on consecutive cycles.
